// File: rtl/reset_seq.sv
// Reset sequencer: debounced button, software and power-on reset with staged domain release.
// Define RESET_SEQ_CAUSE_EN to add the last-reset-cause register on cause_o.
module reset_seq #(
  parameter int DEBOUNCE_CYCLES    = 4,
  parameter int MIN_PULSE_CYCLES   = 4,
  parameter int RELEASE_GAP_CYCLES = 2,
  parameter int NUM_DOMAINS        = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   btn_n_i,
  input  logic                   sw_rst_i,
  output logic [NUM_DOMAINS-1:0] rst_o,
  output logic                   ready_o,
  output logic [1:0]             cause_o
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PC_W = $clog2(MIN_PULSE_CYCLES + 1);
  localparam int GC_W = $clog2(RELEASE_GAP_CYCLES + 1);
  localparam int IX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PC_W-1:0] PC_MAX = PC_W'(MIN_PULSE_CYCLES - 1);
  localparam logic [GC_W-1:0] GC_MAX = GC_W'(RELEASE_GAP_CYCLES - 1);
  localparam logic [IX_W-1:0] IX_MAX = IX_W'(NUM_DOMAINS - 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  logic            r_sync1;
  logic            r_sync2;
  logic            r_stable;
  logic [DB_W-1:0] r_dbcnt;
  logic            r_press;
  state_t          r_state;
  logic [PC_W-1:0] r_pcnt;
  logic [GC_W-1:0] r_gcnt;
  logic [IX_W-1:0] r_idx;
  logic            w_restart;

  assign w_restart = r_press | sw_rst_i;

  // press pulses for one cycle when the debounced level falls
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_stable <= 1'b1;
      r_dbcnt  <= '0;
      r_press  <= 1'b0;
    end else begin
      r_sync1 <= btn_n_i;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_stable) begin
        r_dbcnt <= '0;
      end else if (r_dbcnt == DB_MAX) begin
        r_stable <= r_sync2;
        r_dbcnt  <= '0;
        r_press  <= r_stable;
      end else begin
        r_dbcnt <= r_dbcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_ASSERT;
      rst_o   <= '1;
      ready_o <= 1'b0;
      r_pcnt  <= '0;
      r_gcnt  <= '0;
      r_idx   <= '0;
    end else if (w_restart) begin
      r_state <= ST_ASSERT;
      rst_o   <= '1;
      ready_o <= 1'b0;
      r_pcnt  <= '0;
      r_gcnt  <= '0;
      r_idx   <= '0;
    end else begin
      unique case (r_state)
        ST_ASSERT: begin
          rst_o   <= '1;
          ready_o <= 1'b0;
          // a held button stretches the pulse
          if (!r_stable) begin
            r_pcnt <= '0;
          end else if (r_pcnt == PC_MAX) begin
            r_state <= ST_RELEASE;
            r_pcnt  <= '0;
            r_gcnt  <= '0;
            r_idx   <= '0;
          end else begin
            r_pcnt <= r_pcnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (r_gcnt == GC_MAX) begin
            rst_o[r_idx] <= 1'b0;
            r_gcnt       <= '0;
            if (r_idx == IX_MAX) begin
              r_state <= ST_RUN;
              ready_o <= 1'b1;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_gcnt <= r_gcnt + 1'b1;
          end
        end
        ST_RUN: begin
          rst_o   <= '0;
          ready_o <= 1'b1;
        end
        default: begin
          r_state <= ST_ASSERT;
          rst_o   <= '1;
          ready_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef RESET_SEQ_CAUSE_EN
  logic [1:0] r_cause;

  // button wins over a same-cycle software request
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cause <= 2'b01;
    end else if (r_press) begin
      r_cause <= 2'b10;
    end else if (sw_rst_i) begin
      r_cause <= 2'b11;
    end
  end

  assign cause_o = r_cause;
`else
  assign cause_o = 2'b00;
`endif

endmodule

// File: tb/tb_reset_seq.sv
// Self-checking bench for reset_seq against a cycle-count reference model.
// Honors RESET_SEQ_CAUSE_EN the same way as the design.
module tb_reset_seq;

  localparam int DB  = 4;
  localparam int MP  = 4;
  localparam int GAP = 2;
  localparam int ND  = 3;
  localparam int T_READY = MP + ND * GAP;

`ifdef RESET_SEQ_CAUSE_EN
  localparam logic [1:0] POR_C = 2'b01;
  localparam logic [1:0] BTN_C = 2'b10;
`else
  localparam logic [1:0] POR_C = 2'b00;
  localparam logic [1:0] BTN_C = 2'b00;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          btn_n_i = 1'b1;
  logic          sw_rst_i = 1'b0;
  logic [ND-1:0] rst_o;
  logic          ready_o;
  logic [1:0]    cause_o;

  int checks = 0;
  int failures = 0;

  // reference model state
  int         m_s1, m_s2, m_stable, m_run, m_el;
  bit         m_press;
  logic [1:0] m_cause;

  reset_seq #(
    .DEBOUNCE_CYCLES(DB),
    .MIN_PULSE_CYCLES(MP),
    .RELEASE_GAP_CYCLES(GAP),
    .NUM_DOMAINS(ND)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .btn_n_i(btn_n_i),
    .sw_rst_i(sw_rst_i),
    .rst_o(rst_o),
    .ready_o(ready_o),
    .cause_o(cause_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_reset();
    m_s1 = 1; m_s2 = 1; m_stable = 1;
    m_run = 0; m_press = 0; m_el = 0;
    m_cause = 2'b01;
  endtask

  // m_el = edges since restart, frozen at 0 while the button is held in ASSERT
  task automatic model_edge();
    if (m_press || sw_rst_i) begin
      m_el = 0;
      m_cause = m_press ? 2'b10 : 2'b11;
    end else if (m_el < MP && m_stable == 0) begin
      m_el = 0;
    end else if (m_el < T_READY) begin
      m_el++;
    end
    m_press = 0;
    if (m_s2 != m_stable) begin
      m_run++;
      if (m_run == DB) begin
        m_stable = m_s2;
        m_run = 0;
        m_press = (m_stable == 0);
      end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = int'(btn_n_i);
  endtask

  function automatic logic [ND+2:0] exp_vec();
    logic [ND-1:0] r;
    logic [1:0] c;
    for (int k = 0; k < ND; k++) r[k] = (m_el < MP + (k + 1) * GAP);
`ifdef RESET_SEQ_CAUSE_EN
    c = m_cause;
`else
    c = 2'b00;
`endif
    return {r, (m_el >= T_READY), c};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      checks++;
      if ({rst_o, ready_o, cause_o} !== {3'b111, 1'b0, POR_C}) begin
        failures++;
        $display("FAIL por_hold got=%b want=%b", {rst_o, ready_o, cause_o}, {3'b111, 1'b0, POR_C});
      end
    end
    rst_i = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      checks++;
      if ({rst_o, ready_o, cause_o} !== exp_vec()) begin
        failures++;
        $display("FAIL por_seq edge=%0d got=%b want=%b", e, {rst_o, ready_o, cause_o}, exp_vec());
      end
      if (e == 6 || e == 8 || e == 10) begin
        checks++;
        if (rst_o[(e - 6) / 2] !== 1'b0) begin
          failures++;
          $display("FAIL por_release edge=%0d got=%b want bit %0d low", e, rst_o, (e - 6) / 2);
        end
      end
    end
  endtask

  task automatic test_bounce();
    btn_n_i = 1'b0;
    tick(); tick();
    btn_n_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (rst_o !== 3'b000 || ready_o !== 1'b1) begin
        failures++;
        $display("FAIL bounce_ignored cyc=%0d got=%b/%b want=000/1", i, rst_o, ready_o);
      end
    end
    btn_n_i = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if ({rst_o, ready_o, cause_o} !== exp_vec()) begin
        failures++;
        $display("FAIL btn_hold cyc=%0d got=%b want=%b", i, {rst_o, ready_o, cause_o}, exp_vec());
      end
      if (i == 7) begin
        checks++;
        if ({rst_o, ready_o, cause_o} !== {3'b111, 1'b0, BTN_C}) begin
          failures++;
          $display("FAIL btn_edge7 got=%b want=%b", {rst_o, ready_o, cause_o}, {3'b111, 1'b0, BTN_C});
        end
      end
    end
    btn_n_i = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      checks++;
      if ({rst_o, ready_o, cause_o} !== exp_vec()) begin
        failures++;
        $display("FAIL btn_release cyc=%0d got=%b want=%b", i, {rst_o, ready_o, cause_o}, exp_vec());
      end
    end
  endtask

  task automatic test_sw();
    sw_rst_i = 1'b1;
    tick();
    sw_rst_i = 1'b0;
    checks++;
    if (rst_o !== 3'b111 || ready_o !== 1'b0) begin
      failures++;
      $display("FAIL sw_assert got=%b/%b want=111/0", rst_o, ready_o);
    end
    for (int j = 1; j <= 12; j++) begin
      tick();
      checks++;
      if ({rst_o, ready_o, cause_o} !== exp_vec()) begin
        failures++;
        $display("FAIL sw_seq cyc=%0d got=%b want=%b", j, {rst_o, ready_o, cause_o}, exp_vec());
      end
      if (j == 5 || j == 6) begin
        checks++;
        if (rst_o[0] !== (j == 5)) begin
          failures++;
          $display("FAIL sw_bit0 cyc=%0d got=%b want=%b", j, rst_o[0], (j == 5));
        end
      end
    end
  endtask

  task automatic test_simul();
    btn_n_i = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    sw_rst_i = 1'b1;
    tick();
    sw_rst_i = 1'b0;
    checks++;
    if ({rst_o, ready_o, cause_o} !== {3'b111, 1'b0, BTN_C}) begin
      failures++;
      $display("FAIL simul_cause got=%b want=%b", {rst_o, ready_o, cause_o}, {3'b111, 1'b0, BTN_C});
    end
    btn_n_i = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      checks++;
      if ({rst_o, ready_o, cause_o} !== exp_vec()) begin
        failures++;
        $display("FAIL simul_seq cyc=%0d got=%b want=%b", i, {rst_o, ready_o, cause_o}, exp_vec());
      end
    end
  endtask

  task automatic test_async();
    sw_rst_i = 1'b1;
    tick();
    sw_rst_i = 1'b0;
    for (int i = 0; i < 20 && m_el < MP + GAP; i++) tick();
    checks++;
    if (rst_o !== 3'b110) begin
      failures++;
      $display("FAIL async_pre got=%b want=110", rst_o);
    end
    rst_i = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({rst_o, ready_o, cause_o} !== {3'b111, 1'b0, POR_C}) begin
      failures++;
      $display("FAIL async_now got=%b want=%b", {rst_o, ready_o, cause_o}, {3'b111, 1'b0, POR_C});
    end
    #1;
    rst_i = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      checks++;
      if ({rst_o, ready_o, cause_o} !== exp_vec()) begin
        failures++;
        $display("FAIL async_seq edge=%0d got=%b want=%b", e, {rst_o, ready_o, cause_o}, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    int seg;
    bit lvl;
    for (int n = 0; n < 40; n++) begin
      seg = int'($urandom_range(1, 25));
      lvl = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < seg; i++) begin
        btn_n_i = ($urandom_range(0, 5) == 0) ? ~lvl : lvl;
        sw_rst_i = ($urandom_range(0, 39) == 0);
        tick();
        checks++;
        if ({rst_o, ready_o, cause_o} !== exp_vec()) begin
          failures++;
          $display("FAIL rand seg=%0d got=%b want=%b", n, {rst_o, ready_o, cause_o}, exp_vec());
        end
      end
    end
    btn_n_i = 1'b1;
    sw_rst_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if ({rst_o, ready_o, cause_o} !== exp_vec()) begin
        failures++;
        $display("FAIL rand_settle cyc=%0d got=%b want=%b", i, {rst_o, ready_o, cause_o}, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_sw();
    test_simul();
    test_async();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
